// File: rtl/plic_pkg.sv
// plic_pkg: shared defaults, ID-width helper and typedefs for the PLIC target core.
package plic_pkg;

  localparam int IRQ_NUM_DEF        = 3;
  localparam int IRQ_PRIO_WIDTH_DEF = 3;

  // Width of a claim/complete ID for n sources; never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_WIDTH_DEF = id_width(IRQ_NUM_DEF);

  typedef logic [ID_WIDTH_DEF-1:0]       irq_id_t;
  typedef logic [IRQ_PRIO_WIDTH_DEF-1:0] irq_prio_t;

endpackage

// File: rtl/plic_target_if.sv
// plic_target_if: gateway handshake, register-file configuration and claim/complete
// signals of one PLIC target.
//   master : gateways + APB register front-end (drive requests, config, strobes)
//   slave  : plic_target core (drives ready, completion pulses, claim ID, IP view, irq)
interface plic_target_if
  import plic_pkg::*;
#(
  parameter int IRQ_NUM        = IRQ_NUM_DEF,
  parameter int IRQ_PRIO_WIDTH = IRQ_PRIO_WIDTH_DEF
) ();
  localparam int ID_WIDTH = id_width(IRQ_NUM);

  logic [IRQ_NUM-1:0]                gw_valid_i;
  logic [IRQ_NUM-1:0]                gw_ready_o;
  logic [IRQ_NUM-1:0]                gw_comp_o;
  logic [IRQ_NUM*IRQ_PRIO_WIDTH-1:0] prio_i;
  logic [IRQ_NUM-1:0]                ie_i;
  logic [IRQ_PRIO_WIDTH-1:0]         thold_i;
  logic                              claim_i;
  logic [ID_WIDTH-1:0]               claim_id_o;
  logic                              comp_i;
  logic [ID_WIDTH-1:0]               comp_id_i;
  logic [IRQ_NUM-1:0]                ip_o;
  logic                              ext_irq_o;

  modport master (
    output gw_valid_i, prio_i, ie_i, thold_i, claim_i, comp_i, comp_id_i,
    input  gw_ready_o, gw_comp_o, claim_id_o, ip_o, ext_irq_o
  );

  modport slave (
    input  gw_valid_i, prio_i, ie_i, thold_i, claim_i, comp_i, comp_id_i,
    output gw_ready_o, gw_comp_o, claim_id_o, ip_o, ext_irq_o
  );
endinterface

// File: rtl/plic_max_tree.sv
// plic_max_tree: combinational max-priority selector over the candidate sources.
//   cand_i : candidate mask (pending & enabled)
//   prio_i : packed priorities, source i at [i*W +: W]
//   id_o   : winning source ID (0 when nothing qualifies)
//   prio_o : winning priority (0 when nothing qualifies)
// Leaves are laid out in a binary heap; the left child always holds the lower IDs,
// so a strict '>' at each node makes the lower ID win ties. Non-candidates and
// padding leaves carry priority 0, which never beats anything.
module plic_max_tree #(
  parameter int IRQ_NUM        = 3,
  parameter int IRQ_PRIO_WIDTH = 3,
  parameter int ID_WIDTH       = 2
) (
  input  logic [IRQ_NUM-1:0]                cand_i,
  input  logic [IRQ_NUM*IRQ_PRIO_WIDTH-1:0] prio_i,
  output logic [ID_WIDTH-1:0]               id_o,
  output logic [IRQ_PRIO_WIDTH-1:0]         prio_o
);
  localparam int LEAVES = 1 << ID_WIDTH;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [IRQ_PRIO_WIDTH-1:0] node_prio [NODES];
  logic [ID_WIDTH-1:0]       node_id   [NODES];

  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      node_prio[n] = '0;
      node_id[n]   = '0;
    end
    for (int i = 0; i < IRQ_NUM; i++) begin
      node_id[LEAVES-1+i] = ID_WIDTH'(i);
      if (cand_i[i]) node_prio[LEAVES-1+i] = prio_i[i*IRQ_PRIO_WIDTH +: IRQ_PRIO_WIDTH];
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (node_prio[2*k+2] > node_prio[2*k+1]) begin
        node_prio[k] = node_prio[2*k+2];
        node_id[k]   = node_id[2*k+2];
      end else begin
        node_prio[k] = node_prio[2*k+1];
        node_id[k]   = node_id[2*k+1];
      end
    end
    id_o   = node_id[0];
    prio_o = node_prio[0];
  end
endmodule

// File: rtl/plic_target.sv
// plic_target: per-target PLIC core behind the per-source gateways.
//   clk_i : single clock
//   rst_i : asynchronous active-high reset
//   bus   : plic_target_if.slave (gateway handshake, prio/ie/thold, claim/complete,
//           IP view, ext_irq_o)
// Pending bits are set through the gateway handshake, arbitration is registered
// (one cycle from pending change to best_*), and claim/complete move a source between
// pending and claimed, returning a one-cycle completion pulse to the gateway.
module plic_target
  import plic_pkg::*;
#(
  parameter int IRQ_NUM        = IRQ_NUM_DEF,
  parameter int IRQ_PRIO_WIDTH = IRQ_PRIO_WIDTH_DEF
) (
  input logic         clk_i,
  input logic         rst_i,
  plic_target_if.slave bus
);
  localparam int ID_WIDTH = id_width(IRQ_NUM);

  logic [IRQ_NUM-1:0]        ip_q, claimed_q, comp_q;
  logic [IRQ_NUM-1:0]        gw_ready, cand, claim_oh, comp_hit, comp_oh;
  logic [ID_WIDTH-1:0]       best_id_q, tree_id, claim_id;
  logic [IRQ_PRIO_WIDTH-1:0] best_prio_q, tree_prio;
  logic                      best_vld_q, ext_irq, claim_eff;

  // Source 0 is reserved as "no interrupt" and can never be requested.
  assign gw_ready = {~ip_q[IRQ_NUM-1:1], 1'b0};
  assign cand     = ip_q & bus.ie_i;

  plic_max_tree #(
    .IRQ_NUM        (IRQ_NUM),
    .IRQ_PRIO_WIDTH (IRQ_PRIO_WIDTH),
    .ID_WIDTH       (ID_WIDTH)
  ) u_max_tree (
    .cand_i (cand),
    .prio_i (bus.prio_i),
    .id_o   (tree_id),
    .prio_o (tree_prio)
  );

  // best_vld_q drops for one cycle after a claim so the stale best_* (still
  // pointing at the source just claimed) cannot be claimed a second time.
  assign ext_irq   = best_vld_q && (best_prio_q > bus.thold_i);
  assign claim_id  = ext_irq ? best_id_q : '0;
  assign claim_eff = bus.claim_i && (claim_id != '0);

  // One-hot claim/complete decode; IDs 0 and >= IRQ_NUM never match, and
  // completing the ID claimed in the same cycle is dropped.
  always_comb begin
    claim_oh = '0;
    comp_hit = '0;
    for (int i = 1; i < IRQ_NUM; i++) begin
      claim_oh[i] = claim_eff && (claim_id == ID_WIDTH'(i));
      comp_hit[i] = bus.comp_i && (bus.comp_id_i == ID_WIDTH'(i)) && claimed_q[i];
    end
    comp_oh = comp_hit & ~claim_oh;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ip_q        <= '0;
      claimed_q   <= '0;
      comp_q      <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      best_vld_q  <= 1'b0;
    end else begin
      ip_q        <= (ip_q | (bus.gw_valid_i & gw_ready)) & ~claim_oh;
      claimed_q   <= (claimed_q | claim_oh) & ~comp_oh;
      comp_q      <= comp_oh;
      best_id_q   <= tree_id;
      best_prio_q <= tree_prio;
      best_vld_q  <= ~claim_eff;
    end
  end

  assign bus.gw_ready_o = gw_ready;
  assign bus.gw_comp_o  = comp_q;
  assign bus.claim_id_o = claim_id;
  assign bus.ip_o       = ip_q;
  assign bus.ext_irq_o  = ext_irq;
endmodule

// File: tb/tb_plic_target.sv
// tb_plic_target: scoreboard bench for plic_target with 3 sources, 3-bit priority.
module tb_plic_target;
  import plic_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  plic_target_if #(.IRQ_NUM(3), .IRQ_PRIO_WIDTH(3)) bus ();

  plic_target #(.IRQ_NUM(3), .IRQ_PRIO_WIDTH(3)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int observe(input string tag);
    case (tag)
      "ip":    return int'(bus.ip_o);
      "ready": return int'(bus.gw_ready_o);
      "comp":  return int'(bus.gw_comp_o);
      "irq":   return int'(bus.ext_irq_o);
      "cid":   return int'(bus.claim_id_o);
      default: return -1;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.tag), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [8:0] pk(input irq_prio_t p2, input irq_prio_t p1);
    return {p2, p1, 3'd0};
  endfunction

  initial begin
    bus.gw_valid_i = '0;
    bus.prio_i     = '0;
    bus.ie_i       = '0;
    bus.thold_i    = '0;
    bus.claim_i    = 1'b0;
    bus.comp_i     = 1'b0;
    bus.comp_id_i  = '0;

    // reset state
    #3;
    expect_val("ip", 0); expect_val("ready", 3'b110); expect_val("comp", 0);
    expect_val("irq", 0); expect_val("cid", 0);
    drain();
    #9 rst_i = 1'b0;
    tick();

    // 1: single source, handshake and claim
    bus.prio_i = pk(3'd3, 3'd0);
    bus.ie_i   = 3'b110;
    bus.thold_i = 3'd0;
    bus.gw_valid_i = 3'b100;
    tick();
    bus.gw_valid_i = 3'b000;
    expect_val("ip", 3'b100); expect_val("ready", 3'b010); expect_val("irq", 0);
    drain();
    tick();
    expect_val("irq", 1); drain();
    bus.claim_i = 1'b1; #1;
    expect_val("cid", 2); drain();
    tick();
    bus.claim_i = 1'b0;
    expect_val("ip", 0); expect_val("irq", 0); expect_val("ready", 3'b110);
    drain();

    // 5: completion pulse, then ignored completes
    bus.comp_i = 1'b1; bus.comp_id_i = 2'd2;
    tick();
    expect_val("comp", 3'b100); drain();
    tick();
    expect_val("comp", 0); drain();
    bus.comp_id_i = 2'd0;
    tick();
    expect_val("comp", 0); drain();
    bus.comp_id_i = 2'd3;
    tick();
    expect_val("comp", 0); drain();
    bus.comp_i = 1'b0;
    tick();

    // 2: equal priorities, lower ID first, stale-best dip after a claim
    bus.prio_i = pk(3'd5, 3'd5);
    bus.gw_valid_i = 3'b110;
    tick();
    bus.gw_valid_i = 3'b000;
    expect_val("ip", 3'b110); drain();
    tick();
    expect_val("irq", 1); drain();
    bus.claim_i = 1'b1; #1;
    expect_val("cid", 1); drain();
    tick();
    bus.claim_i = 1'b0;
    expect_val("ip", 3'b100); expect_val("irq", 0); drain();
    tick();
    expect_val("irq", 1); drain();
    bus.claim_i = 1'b1; #1;
    expect_val("cid", 2); drain();
    tick();
    bus.claim_i = 1'b0;
    expect_val("ip", 0); drain();
    bus.comp_i = 1'b1; bus.comp_id_i = 2'd1;
    tick();
    expect_val("comp", 3'b010); drain();
    bus.comp_id_i = 2'd2;
    tick();
    expect_val("comp", 3'b100); drain();
    bus.comp_i = 1'b0;
    tick();
    expect_val("comp", 0); drain();

    // 3: threshold is strict and acts immediately
    bus.prio_i = pk(3'd3, 3'd0);
    bus.thold_i = 3'd3;
    bus.gw_valid_i = 3'b100;
    tick();
    bus.gw_valid_i = 3'b000;
    expect_val("ip", 3'b100); drain();
    tick();
    expect_val("irq", 0); drain();
    bus.claim_i = 1'b1; #1;
    expect_val("cid", 0); drain();
    tick();
    expect_val("ip", 3'b100); drain();
    bus.thold_i = 3'd2; #1;
    expect_val("irq", 1); expect_val("cid", 2); drain();

    // 4: back-to-back claims; only the first takes effect
    tick();
    expect_val("cid", 0); expect_val("ip", 0); drain();
    tick();
    bus.claim_i = 1'b0;
    expect_val("ip", 0); drain();
    bus.comp_i = 1'b1; bus.comp_id_i = 2'd1;
    tick();
    expect_val("comp", 0); drain();
    bus.comp_id_i = 2'd2;
    tick();
    expect_val("comp", 3'b100); drain();
    bus.comp_i = 1'b0;
    tick();

    // 6: reset in the middle of a cycle with pending and claimed state
    bus.thold_i = 3'd0;
    bus.prio_i = pk(3'd1, 3'd2);
    bus.gw_valid_i = 3'b010;
    tick();
    bus.gw_valid_i = 3'b000;
    tick();
    bus.claim_i = 1'b1; #1;
    expect_val("cid", 1); drain();
    tick();
    bus.claim_i = 1'b0;
    bus.gw_valid_i = 3'b110;
    tick();
    bus.gw_valid_i = 3'b000;
    expect_val("ip", 3'b110); drain();
    #3 rst_i = 1'b1;
    #1;
    expect_val("ip", 0); expect_val("irq", 0); expect_val("comp", 0);
    expect_val("ready", 3'b110); expect_val("cid", 0);
    drain();
    #3 rst_i = 1'b0;
    tick();
    tick();
    expect_val("ip", 0); expect_val("irq", 0); drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
